// File: rtl/pong_pkg.sv
// Shared Pong geometry, screen limits and game-state encoding.
// pixel_gen imports this too, so drawn objects line up with the physics here.
package pong_pkg;

    typedef logic [9:0] coord_t;

    localparam coord_t H_PIX     = 10'd640;
    localparam coord_t V_PIX     = 10'd480;
    localparam coord_t BALL_SIZE = 10'd8;
    localparam coord_t WALL_X_R  = 10'd71;
    localparam coord_t PAD_X_L   = 10'd600;
    localparam coord_t PAD_X_R   = 10'd603;
    localparam coord_t PAD_H     = 10'd72;
    localparam coord_t VEL       = 10'd2;
    localparam coord_t SERVE_X   = 10'd320;
    localparam coord_t SERVE_Y   = 10'd240;

    localparam int MISS_FRAMES = 60;
    localparam int MISS_CNT_W  = $clog2(MISS_FRAMES);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/bcd_sat_inc.sv
// Two-digit BCD rally counter: clear wins over enable, increments stick at 99.
// Registered output, one clock from clr_i/en_i to bcd_o; no backpressure.
module bcd_sat_inc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [7:0] bcd_o
);

    logic [7:0] bcd_q;
    logic [7:0] bcd_d;

    always_comb begin
        bcd_d = bcd_q;
        if (clr_i) begin
            bcd_d = 8'h00;
        end else if (en_i && (bcd_q != 8'h99)) begin
            if (bcd_q[3:0] == 4'd9) begin
                bcd_d = {bcd_q[7:4] + 4'd1, 4'd0};
            end else begin
                bcd_d = {bcd_q[7:4], bcd_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= 8'h00;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball engine: per-frame ball motion, wall/paddle reversals, rally score, serve/miss FSM.
// Everything advances only on the frame tick in vertical blanking; outputs lag that tick by one clock.
module ball_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] pad_y_t,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [7:0] score,
    output logic       hit,
    output logic       miss,
    output logic [1:0] state
);

    localparam coord_t X_WALL_LIM = WALL_X_R + 10'd1 + VEL;
    localparam coord_t Y_BOT_LIM  = V_PIX - 10'd1 - VEL;
    localparam logic [MISS_CNT_W-1:0] MISS_LAST = MISS_CNT_W'(MISS_FRAMES - 1);

    state_t                state_q, state_d;
    coord_t                bx_q, bx_d;
    coord_t                by_q, by_d;
    logic                  dir_x_q, dir_x_d;
    logic                  dir_y_q, dir_y_d;
    logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic                  hit_q, hit_d;
    logic                  miss_q, miss_d;

    logic   refr_tick;
    coord_t ball_x_end;
    coord_t ball_y_end;
    coord_t pad_y_b;
    logic   dir_x_new;
    logic   dir_y_new;
    logic   pad_contact;
    logic   score_clr;
    logic   score_inc;

    // One cycle per frame: first pixel of the line just below the visible area plus one.
    assign refr_tick  = p_tick && (x == 10'd0) && (y == (V_PIX + 10'd1));
    assign ball_x_end = bx_q + (BALL_SIZE - 10'd1);
    assign ball_y_end = by_q + (BALL_SIZE - 10'd1);
    assign pad_y_b    = pad_y_t + (PAD_H - 10'd1);

    // Wall reversals are decided first; the paddle test then sees the updated x direction.
    always_comb begin
        dir_y_new = dir_y_q;
        if (by_q < VEL) begin
            dir_y_new = DIR_DOWN;
        end else if (ball_y_end > Y_BOT_LIM) begin
            dir_y_new = DIR_UP;
        end

        dir_x_new = dir_x_q;
        if (bx_q < X_WALL_LIM) begin
            dir_x_new = DIR_RIGHT;
        end

        pad_contact = (dir_x_new == DIR_RIGHT) &&
                      (ball_x_end >= PAD_X_L) && (ball_x_end <= PAD_X_R) &&
                      (by_q <= pad_y_b) && (ball_y_end >= pad_y_t);
    end

    always_comb begin
        state_d    = state_q;
        bx_d       = bx_q;
        by_d       = by_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        miss_cnt_d = miss_cnt_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        score_clr  = 1'b0;
        score_inc  = 1'b0;

        case (state_q)
            ST_SERVE: begin
                bx_d    = SERVE_X;
                by_d    = SERVE_Y;
                dir_x_d = DIR_LEFT;
                dir_y_d = DIR_DOWN;
                if (refr_tick && serve) begin
                    state_d   = ST_PLAY;
                    score_clr = 1'b1;
                end
            end

            ST_PLAY: begin
                if (refr_tick) begin
                    dir_y_d = dir_y_new;
                    dir_x_d = dir_x_new;
                    if (!pad_contact && (ball_x_end > PAD_X_R)) begin
                        miss_d     = 1'b1;
                        state_d    = ST_MISS;
                        miss_cnt_d = '0;
                    end else begin
                        if (pad_contact) begin
                            dir_x_d   = DIR_LEFT;
                            hit_d     = 1'b1;
                            score_inc = 1'b1;
                        end
                        bx_d = (dir_x_d == DIR_RIGHT) ? (bx_q + VEL) : (bx_q - VEL);
                        by_d = (dir_y_d == DIR_DOWN)  ? (by_q + VEL) : (by_q - VEL);
                    end
                end
            end

            ST_MISS: begin
                if (refr_tick) begin
                    if (miss_cnt_q == MISS_LAST) begin
                        state_d    = ST_SERVE;
                        bx_d       = SERVE_X;
                        by_d       = SERVE_Y;
                        dir_x_d    = DIR_LEFT;
                        dir_y_d    = DIR_DOWN;
                        miss_cnt_d = '0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_SERVE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SERVE;
            bx_q       <= SERVE_X;
            by_q       <= SERVE_Y;
            dir_x_q    <= DIR_LEFT;
            dir_y_q    <= DIR_DOWN;
            miss_cnt_q <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            miss_cnt_q <= miss_cnt_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    bcd_sat_inc u_score (
        .clk   (clk),
        .rst   (reset),
        .clr_i (score_clr),
        .en_i  (score_inc),
        .bcd_o (score)
    );

    assign ball_x = bx_q;
    assign ball_y = by_q;
    assign hit    = hit_q;
    assign miss   = miss_q;
    assign state  = state_q;

endmodule
